// File: rtl/row_sequencer.sv
// Player-row sequencer: bounces the active block across the current row on each tick,
// reports the placement on drop and climbs the tower one row at a time until the top row is placed.
module row_sequencer #(
  parameter int NUM_ROWS  = 7,
  parameter int ROW_W     = 5,
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int Y_BASE    = 104,
  parameter int ROW_PITCH = 16,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 144,
  parameter int X_STEP    = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             tick,
  input  logic             drop,
  output logic [X_W-1:0]   x_pos,
  output logic [Y_W-1:0]   y_pos,
  output logic             direction,
  output logic [ROW_W-1:0] row,
  output logic             active,
  output logic             place_valid,
  output logic [X_W-1:0]   place_x,
  output logic [ROW_W-1:0] place_row,
  output logic             done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MOVE = 2'd1;
  localparam logic [1:0] S_ADV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [X_W:0]     X_MIN_E  = (X_W+1)'(X_MIN);
  localparam logic [X_W:0]     X_MAX_E  = (X_W+1)'(X_MAX);
  localparam logic [X_W:0]     X_STEP_E = (X_W+1)'(X_STEP);
  localparam logic [ROW_W-1:0] ROW_TOP  = ROW_W'(NUM_ROWS - 1);

  logic [1:0]       state_q, state_d;
  logic [X_W-1:0]   x_q, x_d, place_x_q, place_x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic             dir_q, dir_d, active_q, active_d, done_q, done_d;
  logic             place_valid_q, place_valid_d;
  logic [ROW_W-1:0] row_q, row_d, place_row_q, place_row_d;

  // Edge checks are one bit wider than x so neither step can wrap.
  logic [X_W:0] x_up;
  logic         hit_right, hit_left;
  assign x_up      = {1'b0, x_q} + X_STEP_E;
  assign hit_right = x_up > X_MAX_E;
  assign hit_left  = {1'b0, x_q} < (X_MIN_E + X_STEP_E);

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    dir_d         = dir_q;
    row_d         = row_q;
    place_valid_d = 1'b0;
    place_x_d     = place_x_q;
    place_row_d   = place_row_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_MOVE;
      S_MOVE: begin
        if (drop) begin
          place_valid_d = 1'b1;
          place_x_d     = x_q;
          place_row_d   = row_q;
          state_d       = S_ADV;
        end else if (tick) begin
          if (dir_q) begin
            if (hit_right) begin
              x_d   = X_MAX_E[X_W-1:0];
              dir_d = 1'b0;
            end else begin
              x_d = x_up[X_W-1:0];
            end
          end else if (hit_left) begin
            x_d   = X_MIN_E[X_W-1:0];
            dir_d = 1'b1;
          end else begin
            x_d = x_q - X_STEP_E[X_W-1:0];
          end
        end
      end
      S_ADV: begin
        if (row_q == ROW_TOP) begin
          state_d = S_DONE;
        end else begin
          row_d   = row_q + 1'b1;
          y_d     = y_q - Y_W'(ROW_PITCH);
          // New row is odd exactly when the current row is even.
          dir_d   = row_q[0];
          x_d     = row_q[0] ? X_MIN_E[X_W-1:0] : X_MAX_E[X_W-1:0];
          state_d = S_MOVE;
        end
      end
      default: begin
        if (start) begin
          row_d   = '0;
          x_d     = X_MIN_E[X_W-1:0];
          y_d     = Y_W'(Y_BASE);
          dir_d   = 1'b1;
          state_d = S_MOVE;
        end
      end
    endcase
    active_d = (state_d == S_MOVE);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      x_q           <= X_MIN_E[X_W-1:0];
      y_q           <= Y_W'(Y_BASE);
      dir_q         <= 1'b1;
      row_q         <= '0;
      active_q      <= 1'b0;
      done_q        <= 1'b0;
      place_valid_q <= 1'b0;
      place_x_q     <= '0;
      place_row_q   <= '0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      dir_q         <= dir_d;
      row_q         <= row_d;
      active_q      <= active_d;
      done_q        <= done_d;
      place_valid_q <= place_valid_d;
      place_x_q     <= place_x_d;
      place_row_q   <= place_row_d;
    end
  end

  assign x_pos       = x_q;
  assign y_pos       = y_q;
  assign direction   = dir_q;
  assign row         = row_q;
  assign active      = active_q;
  assign done        = done_q;
  assign place_valid = place_valid_q;
  assign place_x     = place_x_q;
  assign place_row   = place_row_q;

endmodule
